// File: rtl/pong_ball_engine.sv
// Pong ball engine: advances the ball one cell per game tick on a COLS x ROWS grid,
// resolving wall bounces, paddle hits, misses, scoring, serve delay and game-over.
module pong_ball_engine #(
  parameter int COLS        = 16,
  parameter int ROWS        = 8,
  parameter int PADDLE_LEN  = 3,
  parameter int SERVE_TICKS = 4,
  parameter int WIN_SCORE   = 9
) (
  input  logic                    fastclk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    start,
  input  logic [$clog2(ROWS)-1:0] paddle_l,
  input  logic [$clog2(ROWS)-1:0] paddle_r,
  output logic [$clog2(COLS)-1:0] ball_x,
  output logic [$clog2(ROWS)-1:0] ball_y,
  output logic [3:0]              score_l,
  output logic [3:0]              score_r,
  output logic                    point_l,
  output logic                    point_r,
  output logic                    game_over
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  localparam logic [XW-1:0] X_CENTRE       = XW'(COLS / 2);
  localparam logic [XW-1:0] X_RIGHT_LAST   = XW'(COLS - 2);
  localparam logic [XW-1:0] X_RIGHT_BOUNCE = XW'(COLS - 3);
  localparam logic [XW-1:0] X_LEFT_LAST    = XW'(1);
  localparam logic [XW-1:0] X_LEFT_BOUNCE  = XW'(2);
  localparam logic [YW-1:0] Y_CENTRE       = YW'(ROWS / 2);
  localparam logic [YW-1:0] Y_MAX          = YW'(ROWS - 1);
  localparam logic [YW-1:0] Y_TOP_CLAMP    = YW'(ROWS - PADDLE_LEN);
  localparam logic [YW:0]   PLEN           = (YW + 1)'(PADDLE_LEN);
  localparam logic [SW-1:0] SERVE_LAST     = SW'(SERVE_TICKS - 1);
  localparam logic [3:0]    WIN            = 4'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

  state_t          state;
  logic            dx;
  logic            dy;
  logic [SW-1:0]   serve_cnt;

  logic [YW-1:0]   pl_top;
  logic [YW-1:0]   pr_top;
  logic            hit_l;
  logic            hit_r;
  logic            at_left;
  logic            at_right;
  logic [YW-1:0]   y_next;
  logic            dy_next;
  logic [3:0]      score_l_inc;
  logic [3:0]      score_r_inc;

  // Paddles that would hang off the bottom of the grid are pulled back up to fit.
  always_comb begin
    pl_top = (paddle_l > Y_TOP_CLAMP) ? Y_TOP_CLAMP : paddle_l;
    pr_top = (paddle_r > Y_TOP_CLAMP) ? Y_TOP_CLAMP : paddle_r;
    hit_l  = ({1'b0, ball_y} >= {1'b0, pl_top}) &&
             ({1'b0, ball_y} <  ({1'b0, pl_top} + PLEN));
    hit_r  = ({1'b0, ball_y} >= {1'b0, pr_top}) &&
             ({1'b0, ball_y} <  ({1'b0, pr_top} + PLEN));
    at_right = dx  && (ball_x == X_RIGHT_LAST);
    at_left  = !dx && (ball_x == X_LEFT_LAST);
    score_l_inc = score_l + 4'd1;
    score_r_inc = score_r + 4'd1;
  end

  // Vertical step with reflection off the top and bottom walls.
  always_comb begin
    y_next  = ball_y;
    dy_next = dy;
    if (dy && (ball_y == Y_MAX)) begin
      y_next  = Y_MAX - YW'(1);
      dy_next = 1'b0;
    end else if (!dy && (ball_y == '0)) begin
      y_next  = YW'(1);
      dy_next = 1'b1;
    end else if (dy) begin
      y_next = ball_y + YW'(1);
    end else begin
      y_next = ball_y - YW'(1);
    end
  end

  always_ff @(posedge fastclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ball_x    <= X_CENTRE;
      ball_y    <= Y_CENTRE;
      dx        <= 1'b1;
      dy        <= 1'b1;
      serve_cnt <= '0;
      score_l   <= '0;
      score_r   <= '0;
      point_l   <= 1'b0;
      point_r   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      point_l <= 1'b0;
      point_r <= 1'b0;
      case (state)
        IDLE: begin
          ball_x <= X_CENTRE;
          ball_y <= Y_CENTRE;
          if (start) begin
            state     <= SERVE;
            serve_cnt <= '0;
            score_l   <= '0;
            score_r   <= '0;
          end
        end

        SERVE: begin
          ball_x <= X_CENTRE;
          ball_y <= Y_CENTRE;
          if (tick) begin
            if (serve_cnt == SERVE_LAST) begin
              state <= PLAY;
            end else begin
              serve_cnt <= serve_cnt + SW'(1);
            end
          end
        end

        PLAY: begin
          if (tick) begin
            // A miss recentres the ball and serves it toward the player who conceded.
            if (at_right && !hit_r) begin
              score_l   <= score_l_inc;
              point_l   <= 1'b1;
              ball_x    <= X_CENTRE;
              ball_y    <= Y_CENTRE;
              dx        <= 1'b1;
              serve_cnt <= '0;
              if (score_l_inc == WIN) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state <= SERVE;
              end
            end else if (at_left && !hit_l) begin
              score_r   <= score_r_inc;
              point_r   <= 1'b1;
              ball_x    <= X_CENTRE;
              ball_y    <= Y_CENTRE;
              dx        <= 1'b0;
              serve_cnt <= '0;
              if (score_r_inc == WIN) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state <= SERVE;
              end
            end else begin
              ball_y <= y_next;
              dy     <= dy_next;
              if (at_right) begin
                dx     <= 1'b0;
                ball_x <= X_RIGHT_BOUNCE;
              end else if (at_left) begin
                dx     <= 1'b1;
                ball_x <= X_LEFT_BOUNCE;
              end else if (dx) begin
                ball_x <= ball_x + XW'(1);
              end else begin
                ball_x <= ball_x - XW'(1);
              end
            end
          end
        end

        OVER: begin
          ball_x <= X_CENTRE;
          ball_y <= Y_CENTRE;
          if (start) begin
            state     <= SERVE;
            serve_cnt <= '0;
            score_l   <= '0;
            score_r   <= '0;
            game_over <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_ball_engine.sv
// Self-checking bench for pong_ball_engine: directed game scenarios plus randomized
// play, all compared against a velocity-based behavioural model of the game rules.
module tb_pong_ball_engine;

  localparam int COLS        = 16;
  localparam int ROWS        = 8;
  localparam int PADDLE_LEN  = 3;
  localparam int SERVE_TICKS = 4;
  localparam int WIN_SCORE   = 9;

  localparam int S_IDLE  = 0;
  localparam int S_SERVE = 1;
  localparam int S_PLAY  = 2;
  localparam int S_OVER  = 3;

  logic       fastclk;
  logic       reset;
  logic       tick;
  logic       start;
  logic [2:0] paddle_l;
  logic [2:0] paddle_r;
  logic [3:0] ball_x;
  logic [2:0] ball_y;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       point_l;
  logic       point_r;
  logic       game_over;

  int checks   = 0;
  int failures = 0;

  int m_state, m_x, m_y, m_vx, m_vy, m_ticks, m_sl, m_sr, m_pl, m_pr, m_go;

  logic [17:0] dut_vec;
  assign dut_vec = {ball_x, ball_y, score_l, score_r, point_l, point_r, game_over};

  pong_ball_engine #(
    .COLS(COLS), .ROWS(ROWS), .PADDLE_LEN(PADDLE_LEN),
    .SERVE_TICKS(SERVE_TICKS), .WIN_SCORE(WIN_SCORE)
  ) dut (
    .fastclk(fastclk), .reset(reset), .tick(tick), .start(start),
    .paddle_l(paddle_l), .paddle_r(paddle_r),
    .ball_x(ball_x), .ball_y(ball_y), .score_l(score_l), .score_r(score_r),
    .point_l(point_l), .point_r(point_r), .game_over(game_over)
  );

  initial fastclk = 1'b0;
  always #5 fastclk = ~fastclk;

  task automatic m_reset();
    m_state = S_IDLE; m_x = COLS / 2; m_y = ROWS / 2; m_vx = 1; m_vy = 1;
    m_ticks = 0; m_sl = 0; m_sr = 0; m_pl = 0; m_pr = 0; m_go = 0;
  endtask

  // Game rules stated with signed velocities: the ball reflects off walls, and a
  // step into a paddle column is either turned back by the paddle or scores.
  task automatic model_step(input bit t, input bit s);
    int nx, ny, vy2, p;
    m_pl = 0; m_pr = 0;
    case (m_state)
      S_IDLE: if (s) begin m_state = S_SERVE; m_ticks = 0; m_sl = 0; m_sr = 0; end
      S_SERVE: if (t) begin
        m_ticks++;
        if (m_ticks == SERVE_TICKS) m_state = S_PLAY;
      end
      S_PLAY: if (t) begin
        vy2 = m_vy;
        ny  = m_y + vy2;
        if (ny < 0 || ny > ROWS - 1) begin vy2 = -vy2; ny = m_y + vy2; end
        nx = m_x + m_vx;
        if (nx == 0 || nx == COLS - 1) begin
          p = (nx == 0) ? int'(paddle_l) : int'(paddle_r);
          if (p > ROWS - PADDLE_LEN) p = ROWS - PADDLE_LEN;
          if (m_y >= p && m_y < p + PADDLE_LEN) begin
            m_vx = -m_vx; m_x = m_x + m_vx; m_y = ny; m_vy = vy2;
          end else begin
            if (nx == COLS - 1) begin m_sl++; m_pl = 1; m_vx = 1; end
            else begin m_sr++; m_pr = 1; m_vx = -1; end
            m_x = COLS / 2; m_y = ROWS / 2; m_ticks = 0;
            m_state = (m_sl == WIN_SCORE || m_sr == WIN_SCORE) ? S_OVER : S_SERVE;
          end
        end else begin
          m_x = nx; m_y = ny; m_vy = vy2;
        end
      end
      S_OVER: if (s) begin m_state = S_SERVE; m_sl = 0; m_sr = 0; m_ticks = 0; end
      default: m_state = S_IDLE;
    endcase
    m_go = (m_state == S_OVER) ? 1 : 0;
  endtask

  function automatic logic [17:0] exp_vec();
    return {4'(m_x), 3'(m_y), 4'(m_sl), 4'(m_sr), 1'(m_pl), 1'(m_pr), 1'(m_go)};
  endfunction

  function automatic string dut_s();
    return $sformatf("(%0d,%0d) sl=%0d sr=%0d pl=%0d pr=%0d go=%0d",
                     ball_x, ball_y, score_l, score_r, point_l, point_r, game_over);
  endfunction

  function automatic string mod_s();
    return $sformatf("(%0d,%0d) sl=%0d sr=%0d pl=%0d pr=%0d go=%0d",
                     m_x, m_y, m_sl, m_sr, m_pl, m_pr, m_go);
  endfunction

  // One fastclk cycle: inputs applied before the edge, model advanced at the edge,
  // outputs left settled 1 time unit after it.
  task automatic step(input bit t, input bit s);
    tick = t; start = s;
    @(posedge fastclk);
    model_step(t, s);
    #1;
    tick = 1'b0; start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_reset();
    @(negedge fastclk);
    reset = 1'b0;
  endtask

  task automatic serve();
    step(1'b0, 1'b1);
    repeat (SERVE_TICKS) step(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; start = 1'b0; paddle_l = 3'd0; paddle_r = 3'd3;
    m_reset();
    repeat (2) @(posedge fastclk);
    #1;
    checks++;
    if (dut_vec !== {4'd8, 3'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("[TB] FAIL reset_values: got %s expected (8,4) all zero", dut_s());
    end
    @(negedge fastclk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("[TB] FAIL idle_tick: got %s expected %s", dut_s(), mod_s());
      end
    end
    serve();
    repeat (3) step(1'b1, 1'b0);
    checks++;
    if (ball_x !== 4'd11 || ball_y !== 3'd7) begin
      failures++; $display("[TB] FAIL pre_reset_pos: got %s expected (11,7)", dut_s());
    end
    reset = 1'b1;
    m_reset();
    #1;
    checks++;
    if (dut_vec !== {4'd8, 3'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("[TB] FAIL async_reset: got %s expected (8,4) all zero", dut_s());
    end
    @(negedge fastclk);
    reset = 1'b0;
  endtask

  task automatic test_serve();
    step(1'b1, 1'b1);
    for (int k = 1; k <= SERVE_TICKS; k++) begin
      step(1'b1, 1'b0);
      checks++;
      if (ball_x !== 4'd8 || ball_y !== 3'd4 || dut_vec !== exp_vec()) begin
        failures++; $display("[TB] FAIL serve_hold_%0d: got %s expected (8,4)", k, dut_s());
      end
      step(1'b0, 1'b0);
    end
    step(1'b1, 1'b0);
    checks++;
    if (ball_x !== 4'd9 || ball_y !== 3'd5 || dut_vec !== exp_vec()) begin
      failures++; $display("[TB] FAIL first_move: got %s expected (9,5)", dut_s());
    end
  endtask

  task automatic test_paddle_hit();
    int tx[7] = '{10, 11, 12, 13, 14, 13, 12};
    int ty[7] = '{6, 7, 6, 5, 4, 3, 2};
    paddle_r = 3'd3;
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 1'b0);
      checks++;
      if (int'(ball_x) != tx[k] || int'(ball_y) != ty[k] || dut_vec !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL hit_path_%0d: got %s expected (%0d,%0d)", k, dut_s(), tx[k], ty[k]);
      end
    end
  endtask

  task automatic test_miss();
    do_reset();
    paddle_r = 3'd0;
    serve();
    for (int k = 1; k <= 7; k++) begin
      step(1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("[TB] FAIL miss_tick_%0d: got %s expected %s", k, dut_s(), mod_s());
      end
      if (k == 7) begin
        checks++;
        if (dut_vec !== {4'd8, 3'd4, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0}) begin
          failures++; $display("[TB] FAIL miss_score: got %s expected (8,4) sl=1 pl=1", dut_s());
        end
      end
      repeat (2) begin
        step(1'b0, 1'b0);
        checks++;
        if (dut_vec !== exp_vec()) begin
          failures++; $display("[TB] FAIL miss_gap_%0d: got %s expected %s", k, dut_s(), mod_s());
        end
      end
    end
    repeat (SERVE_TICKS) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (ball_x !== 4'd9 || ball_y !== 3'd3 || score_l !== 4'd1) begin
      failures++; $display("[TB] FAIL reserve_dir: got %s expected (9,3) sl=1", dut_s());
    end
  endtask

  task automatic test_clamp();
    do_reset();
    paddle_r = 3'd7;
    serve();
    repeat (7) step(1'b1, 1'b0);
    checks++;
    if (dut_vec !== {4'd8, 3'd4, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("[TB] FAIL clamp_miss_y4: got %s expected (8,4) sl=1 pl=1", dut_s());
    end
    do_reset();
    paddle_r = 3'd3; paddle_l = 3'd7;
    serve();
    repeat (7 + 12) step(1'b1, 1'b0);
    checks++;
    if (ball_x !== 4'd1 || ball_y !== 3'd5) begin
      failures++; $display("[TB] FAIL clamp_left_pos: got %s expected (1,5)", dut_s());
    end
    step(1'b1, 1'b0);
    checks++;
    if (dut_vec !== {4'd2, 3'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0} || dut_vec !== exp_vec()) begin
      failures++; $display("[TB] FAIL clamp_left_hit_y5: got %s expected (2,4) no score", dut_s());
    end
    paddle_r = 3'd7;
    repeat (12) step(1'b1, 1'b0);
    checks++;
    if (ball_x !== 4'd14 || ball_y !== 3'd6) begin
      failures++; $display("[TB] FAIL clamp_right_pos: got %s expected (14,6)", dut_s());
    end
    step(1'b1, 1'b0);
    checks++;
    if (dut_vec !== {4'd13, 3'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0} || dut_vec !== exp_vec()) begin
      failures++; $display("[TB] FAIL clamp_right_hit_y6: got %s expected (13,5) no score", dut_s());
    end
  endtask

  task automatic test_game_over();
    int n = 0;
    do_reset();
    serve();
    while (m_sl < WIN_SCORE && n < 600) begin
      paddle_r = (m_y <= 3) ? 3'd5 : 3'd0;
      step(1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("[TB] FAIL win_run_%0d: got %s expected %s", n, dut_s(), mod_s());
      end
      step(1'b0, 1'b0);
      n++;
    end
    checks++;
    if (m_sl != WIN_SCORE) begin
      failures++; $display("[TB] FAIL win_budget: got sl=%0d expected %0d within budget", m_sl, WIN_SCORE);
    end
    checks++;
    if (score_l !== 4'd9 || score_r !== 4'd0 || game_over !== 1'b1) begin
      failures++; $display("[TB] FAIL game_over_set: got %s expected sl=9 go=1", dut_s());
    end
    repeat (5) step(1'b1, 1'b0);
    checks++;
    if (dut_vec !== {4'd8, 3'd4, 4'd9, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("[TB] FAIL over_hold: got %s expected (8,4) sl=9 go=1", dut_s());
    end
    step(1'b0, 1'b1);
    checks++;
    if (dut_vec !== {4'd8, 3'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("[TB] FAIL restart: got %s expected (8,4) scores 0 go=0", dut_s());
    end
    for (int k = 0; k <= SERVE_TICKS; k++) begin
      step(1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("[TB] FAIL restart_serve_%0d: got %s expected %s", k, dut_s(), mod_s());
      end
    end
  endtask

  task automatic test_random();
    int p;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 700) begin
        reset = 1'b1;
        m_reset();
        #1;
        checks++;
        if (dut_vec !== exp_vec()) begin
          failures++; $display("[TB] FAIL rand_reset_%0d: got %s expected %s", i, dut_s(), mod_s());
        end
        @(negedge fastclk);
        reset = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) begin
        p = m_y - int'($urandom_range(0, 2));
        if (p < 0) p = 0;
        paddle_l = 3'(p);
        paddle_r = 3'(p);
      end else begin
        paddle_l = 3'($urandom_range(0, 7));
        paddle_r = 3'($urandom_range(0, 7));
      end
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 63) == 0));
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("[TB] FAIL rand_cycle_%0d: got %s expected %s", i, dut_s(), mod_s());
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_paddle_hit();
    test_miss();
    test_clamp();
    test_game_over();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
